quadrature_generator: RTL
=========================

Name: quadrature_generator

Overview:
Synthesises quadrature A/B/I signals for a commanded signed number of counts at a programmable edge rate. It is the transmit-side counterpart of the quadrature decoder. It is used to drive the encoder peripheral's inputs in loopback self-test, and to emulate motor encoders for downstream controllers. A host-side register block drives it with a start/steps/period command and reads back busy/done/position.

Parameters:
CPR, 2048, counts per revolution; I asserted once per CPR counts (must be >= 4).
PERIOD_W, 16, width of the edge-period input.

Ports:
clk_12MHz  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle command strobe, sampled only in IDLE
steps  input  32  signed count to emit; sign selects direction; latched on accepted start
period  input  PERIOD_W  clocks between successive A/B edges; 0 is treated as 1; latched on accepted start
abort  input  1  terminates a run; no done pulse
A  output  1  quadrature channel A (registered)
B  output  1  quadrature channel B (registered)
I  output  1  index, registered; high while index_cnt == 0
busy  output  1  high in RUN
done  output  1  one-cycle pulse at normal completion
position  output  32  signed running count; increments or decrements on every emitted edge

Behaviour:
- Reset values (asynchronous): A=0, B=0, phase=0, index_cnt=0, I=1, position=0, busy=0, done=0, FSM=IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start && !abort && steps!=0.
  - IDLE -> DONE on start && !abort && steps==0. No edges are emitted.
  - RUN -> DONE when the remaining count reaches 0 on the cycle that emits the last edge.
  - RUN -> IDLE on abort.
  - DONE -> IDLE unconditionally after 1 cycle.
- Output timing: done=1 only in DONE. busy=1 only in RUN.
- Accepting a command: on accepted start at clock edge t, latch remaining=|steps|, dir=~steps[31], and per=max(period,1). Clear the divider. busy=1 after edge t.
- Edge generation: the divider counts 0..per-1. The first edge occurs at clock edge t+per; subsequent edges follow every per clocks. Exactly one of A/B toggles per edge.
- Phase sequence: up (dir=1) is AB = 00 -> 10 -> 11 -> 01 -> 00. Down is the reverse.
- Per-edge updates: position +/-1 (wraps modulo 2^32); index_cnt +/-1 modulo CPR; remaining -1.
- Magnitude rule: |steps| computed as a 32-bit two's-complement negate. steps = 0x80000000 yields 2^31 down counts.
- start while busy or in DONE: ignored; latched values unchanged.
- abort in RUN: state goes to IDLE at the next edge. A, B, I and position hold their current values. No done pulse.
- abort in IDLE or DONE: no effect, except that it suppresses a same-cycle start.
- Abort vs last edge: if abort and the last edge coincide, the edge is emitted and position updated, then IDLE with no done pulse.
- Rate limit: period >= 2 is required for the sibling decoder to count without loss. period 0/1 produces one edge per clock and is legal for this block.
- State persistence: A/B/phase/position persist across runs, so consecutive runs continue a seamless waveform.
- Reset mid-run: all state returns to reset values immediately (asynchronous). The run is abandoned.

Optional Feature:
QUADGEN_CONTINUOUS_EN:
- Defined: adds input port `continuous` (1 bit), sampled with start. If continuous=1 on an accepted start, steps is ignored except for its sign bit for direction. remaining is not decremented, and RUN persists until abort (no done pulse). steps==0 with continuous=1 still enters RUN, running up.
- Undefined: the port is absent and only finite runs exist.

Test Plan:
- Reset, then start steps=+8 period=4 -> busy next cycle; first edge 4 clocks after start; AB sequence 10,11,01,00,10,11,01,00; position=8; done pulse 1 cycle after the 8th edge; busy low with done.
- From position 8, start steps=-3 period=2 -> AB 01,11,10 at 2-clock spacing; position=5; direction reversal has no glitch or skipped phase.
- CPR=8, start steps=+17 period=1 -> an edge every clock; I high at position 0 (reset), 8 and 16 only; final position 17, I=0.
- Start steps=+100 period=3, abort after 10 edges -> busy drops next clock; no done pulse; position=10; A/B frozen. A start on the same cycle as abort is ignored.
- Start steps=0 -> done pulse 1 cycle later, busy never asserts, A/B unchanged. Start steps=0x80000000 -> direction down, remaining=2^31 (check the first 4 edges, then abort).
- Loopback against the encoder peripheral's decoder: period=2, steps=+1000 then -250 -> the decoder accumulates 750 total. (QUADGEN_CONTINUOUS_EN build: continuous=1 runs until abort.)

Source files
------------

// File: rtl/quadrature_generator.sv
// Quadrature A/B/I generator: emits a signed number of counts at a programmable edge period.
// Optional build macro QUADGEN_CONTINUOUS_EN adds a `continuous` input that runs until abort.
module quadrature_generator #(
    parameter int CPR      = 2048,
    parameter int PERIOD_W = 16
) (
    input  logic                clk_12MHz,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         steps,
    input  logic [PERIOD_W-1:0] period,
    input  logic                abort,
`ifdef QUADGEN_CONTINUOUS_EN
    input  logic                continuous,
`endif
    output logic                A,
    output logic                B,
    output logic                I,
    output logic                busy,
    output logic                done,
    output logic [31:0]         position
);

    localparam int IDX_W = (CPR > 1) ? $clog2(CPR) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state;
    logic [31:0]         remaining;
    logic                dir;
    logic                cont;
    logic [PERIOD_W-1:0] per;
    logic [PERIOD_W-1:0] div;
    logic [1:0]          phase;
    logic [IDX_W-1:0]    index_cnt;

    logic                cont_in;
    logic                accept;
    logic                edge_now;
    logic                last_edge;
    logic [31:0]         steps_mag;
    logic [1:0]          next_phase;
    logic [IDX_W-1:0]    next_index;

`ifdef QUADGEN_CONTINUOUS_EN
    assign cont_in = continuous;
`else
    assign cont_in = 1'b0;
`endif

    assign accept    = (state == S_IDLE) && start && !abort;
    assign edge_now  = (state == S_RUN) && (div == per - PERIOD_W'(1));
    assign last_edge = edge_now && !cont && (remaining == 32'd1);
    // Plain two's-complement negate: 0x80000000 maps to itself, i.e. 2^31 counts.
    assign steps_mag = steps[31] ? (~steps + 32'd1) : steps;

    assign next_phase = dir ? (phase + 2'd1) : (phase - 2'd1);
    assign next_index = dir ? ((index_cnt == IDX_MAX) ? '0 : index_cnt + IDX_W'(1))
                            : ((index_cnt == '0) ? IDX_MAX : index_cnt - IDX_W'(1));

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // NOTE: every register here is updated with non-blocking assignments so all
    // next-state terms above see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            dir       <= 1'b1;
            cont      <= 1'b0;
            per       <= PERIOD_W'(1);
            div       <= '0;
            phase     <= 2'd0;
            index_cnt <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            I         <= 1'b1;
            position  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remaining <= steps_mag;
                        dir       <= ~steps[31];
                        cont      <= cont_in;
                        per       <= (period == '0) ? PERIOD_W'(1) : period;
                        div       <= '0;
                        state     <= ((steps == '0) && !cont_in) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (edge_now) begin
                        div       <= '0;
                        phase     <= next_phase;
                        // Gray-coded AB: phase 0..3 -> 00, 10, 11, 01.
                        A         <= next_phase[1] ^ next_phase[0];
                        B         <= next_phase[1];
                        index_cnt <= next_index;
                        I         <= (next_index == '0);
                        position  <= dir ? (position + 32'd1) : (position - 32'd1);
                        if (!cont) begin
                            remaining <= remaining - 32'd1;
                        end
                    end else begin
                        div <= div + PERIOD_W'(1);
                    end
                    // Abort wins over completion: the final edge still goes out, but no done pulse.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (last_edge) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
